// File: rtl/mdu_hilo_if.sv
// Request/response bundle between the pipeline and the HI/LO multiply-divide unit.
//   start, op, rsvalue, rtvalue : request side, driven by the pipeline (master)
//   busy, done, div_zero, hi, lo: status and result side, driven by the unit (slave)
interface mdu_hilo_if;
  localparam int unsigned DW = 32;

  logic          start;
  logic [2:0]    op;
  logic [DW-1:0] rsvalue;
  logic [DW-1:0] rtvalue;
  logic          busy;
  logic          done;
  logic          div_zero;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;

  modport master (
    output start, op, rsvalue, rtvalue,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, rsvalue, rtvalue,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mdu_hilo.sv
// HI/LO multiply-divide unit: 32-iteration shift-add multiplier and restoring
// divider writing a 64-bit result into the architectural HI/LO registers,
// plus MTHI/MTLO moves.
// Ports:
//   clk      : clock, all state changes on the rising edge
//   rst      : asynchronous active-high reset
//   bus      : mdu_hilo_if.slave (start/op/rsvalue/rtvalue in;
//              busy/done/div_zero/hi/lo out, all registered)
// Build option:
//   MDU_DIV_EN defined   -> DIV/DIVU perform restoring division.
//   MDU_DIV_EN undefined -> no divider; DIV/DIVU complete one edge after
//                           accept with hi/lo untouched and div_zero low.
module mdu_hilo (
  input  logic      clk,
  input  logic      rst,
  mdu_hilo_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned CW = 5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] acc_q, acc_d;     // product accumulator / division remainder
  logic [PW-1:0] opa_q, opa_d;     // shifting multiplicand / dividend-quotient
  logic [DW-1:0] opb_q, opb_d;     // shifting multiplier / divisor magnitude
  logic          neg_q, neg_d;     // negate product or quotient at the end
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;
  logic          pend_q, pend_d;   // completion without iteration, due next edge
  logic          pend_dz_q, pend_dz_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;

  logic          accept_c;
  logic          signed_op_c;
  logic [DW-1:0] a_mag_c;
  logic [DW-1:0] b_mag_c;
  logic [PW-1:0] prod_c;

`ifdef MDU_DIV_EN
  logic          is_div_q, is_div_d;
  logic          rneg_q, rneg_d;   // negate remainder (dividend was negative)
  logic [DW:0]   rem_sh_c;
  logic [DW:0]   rem_diff_c;
  logic          q_bit_c;
  logic [DW-1:0] rem_c;
`endif

  // Operand conditioning: signed ops work on magnitudes.
  assign accept_c    = bus.start && (state_q == ST_IDLE) && (bus.op[2:1] != 2'b11);
  assign signed_op_c = ~bus.op[0];
  assign a_mag_c     = (signed_op_c && bus.rsvalue[DW-1]) ? (~bus.rsvalue + DW'(1)) : bus.rsvalue;
  assign b_mag_c     = (signed_op_c && bus.rtvalue[DW-1]) ? (~bus.rtvalue + DW'(1)) : bus.rtvalue;

  // Next-state, datapath and output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    pend_d    = 1'b0;
    pend_dz_d = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prod_c    = '0;
`ifdef MDU_DIV_EN
    is_div_d   = is_div_q;
    rneg_d     = rneg_q;
    rem_sh_c   = '0;
    rem_diff_c = '0;
    q_bit_c    = 1'b0;
    rem_c      = '0;
`endif

    // Deferred completion of a non-iterating divide.
    if (pend_q) begin
      done_d = 1'b1;
      dz_d   = pend_dz_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              state_d = ST_RUN;
              busy_d  = 1'b1;
              cnt_d   = '0;
              acc_d   = '0;
              opa_d   = {{DW{1'b0}}, a_mag_c};
              opb_d   = b_mag_c;
              neg_d   = signed_op_c & (bus.rsvalue[DW-1] ^ bus.rtvalue[DW-1]);
`ifdef MDU_DIV_EN
              is_div_d = 1'b0;
`endif
            end
            OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV_EN
              if (bus.rtvalue == '0) begin
                pend_d    = 1'b1;
                pend_dz_d = 1'b1;
              end else begin
                state_d  = ST_RUN;
                busy_d   = 1'b1;
                cnt_d    = '0;
                acc_d    = '0;
                opa_d    = {{DW{1'b0}}, a_mag_c};
                opb_d    = b_mag_c;
                neg_d    = signed_op_c & (bus.rsvalue[DW-1] ^ bus.rtvalue[DW-1]);
                rneg_d   = signed_op_c & bus.rsvalue[DW-1];
                is_div_d = 1'b1;
              end
`else
              pend_d = 1'b1;
`endif
            end
            OP_MTHI: begin
              hi_d   = bus.rsvalue;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.rsvalue;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q + CW'(1);
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          // Restoring step: shift in next dividend bit, subtract if it fits.
          rem_sh_c   = {acc_q[DW-1:0], opa_q[DW-1]};
          rem_diff_c = rem_sh_c - {1'b0, opb_q};
          q_bit_c    = ~rem_diff_c[DW];
          acc_d      = {{DW{1'b0}}, (q_bit_c ? rem_diff_c[DW-1:0] : rem_sh_c[DW-1:0])};
          opa_d      = {{DW{1'b0}}, opa_q[DW-2:0], q_bit_c};
          if (cnt_q == LAST_ITER) begin
            rem_c = acc_d[DW-1:0];
            lo_d  = neg_q  ? (~opa_d[DW-1:0] + DW'(1)) : opa_d[DW-1:0];
            hi_d  = rneg_q ? (~rem_c + DW'(1)) : rem_c;
          end
        end else
`endif
        begin
          // Shift-add step on the multiplier LSB.
          if (opb_q[0]) begin
            acc_d = acc_q + opa_q;
          end
          opa_d = {opa_q[PW-2:0], 1'b0};
          opb_d = {1'b0, opb_q[DW-1:1]};
          if (cnt_q == LAST_ITER) begin
            prod_c = neg_q ? (~acc_d + PW'(1)) : acc_d;
            hi_d   = prod_c[PW-1:DW];
            lo_d   = prod_c[DW-1:0];
          end
        end
        if (cnt_q == LAST_ITER) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dz_d    = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      pend_q    <= 1'b0;
      pend_dz_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MDU_DIV_EN
      is_div_q  <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      pend_q    <= pend_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MDU_DIV_EN
      is_div_q  <= is_div_d;
      rneg_q    <= rneg_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// Testbench for mdu_hilo: directed vectors, randomized operations against an
// arithmetic reference model, MT moves, back-to-back, reserved ops, abort.
// Follows the MDU_DIV_EN setting of the build for DIV/DIVU expectations.
module tb_mdu_hilo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_hilo_if bus();
  mdu_hilo dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  function automatic logic [63:0] ref_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    if (o == 3'b000) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return ua * ub;
  endfunction

`ifdef MDU_DIV_EN
  // Returns {remainder, quotient}.
  function automatic logic [63:0] ref_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    if (o == 3'b010) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction
`endif

  // Issues one op and records what the DUT did; no judging here.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int done_at, output int busy_cyc,
                        output logic [31:0] r_hi, output logic [31:0] r_lo,
                        output logic r_dz, output logic early, output logic done_after);
    logic [31:0] pre_hi, pre_lo;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rsvalue = a; bus.rtvalue = b;
    pre_hi = bus.hi; pre_lo = bus.lo;
    done_at = -1; busy_cyc = 0; early = 1'b0; done_after = 1'b0;
    r_hi = pre_hi; r_lo = pre_lo; r_dz = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        done_at = k; r_hi = bus.hi; r_lo = bus.lo; r_dz = bus.div_zero;
        break;
      end
      if (bus.hi !== pre_hi || bus.lo !== pre_lo) early = 1'b1;
    end
    if (done_at >= 0) begin
      @(negedge clk);
      done_after = bus.done;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0) begin
      errors++; $display("FAIL reset_hilo: got %h required 0", {bus.hi, bus.lo});
    end
    checks++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b required 000", {bus.busy, bus.done, bus.div_zero});
    end
  endtask

  // Checks one op against the model and updates the model's HI/LO.
  task automatic test_one(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int done_at, busy_cyc, e_done, e_busy;
    logic [31:0] r_hi, r_lo, e_hi, e_lo;
    logic r_dz, early, done_after, e_dz;
    logic [63:0] res;
    e_hi = m_hi; e_lo = m_lo; e_dz = 1'b0; e_done = 1; e_busy = 0;
    case (o)
      3'b000, 3'b001: begin
        res = ref_mul(o, a, b); e_hi = res[63:32]; e_lo = res[31:0]; e_done = 32; e_busy = 32;
      end
      3'b010, 3'b011: begin
`ifdef MDU_DIV_EN
        if (b == 32'h0) e_dz = 1'b1;
        else begin
          res = ref_div(o, a, b); e_hi = res[63:32]; e_lo = res[31:0]; e_done = 32; e_busy = 32;
        end
`endif
      end
      3'b100: begin e_hi = a; e_done = 0; end
      default: begin e_lo = a; e_done = 0; end
    endcase
    run_op(o, a, b, done_at, busy_cyc, r_hi, r_lo, r_dz, early, done_after);
    checks++;
    if (done_at != e_done) begin
      errors++; $display("FAIL %s done_time: got %0d required %0d", nm, done_at, e_done);
    end
    checks++;
    if (busy_cyc != e_busy) begin
      errors++; $display("FAIL %s busy_cycles: got %0d required %0d", nm, busy_cyc, e_busy);
    end
    checks++;
    if ({r_hi, r_lo} !== {e_hi, e_lo}) begin
      errors++; $display("FAIL %s hilo op=%0d a=%h b=%h: got %h_%h required %h_%h", nm, o, a, b, r_hi, r_lo, e_hi, e_lo);
    end
    checks++;
    if (r_dz !== e_dz) begin
      errors++; $display("FAIL %s div_zero: got %b required %b", nm, r_dz, e_dz);
    end
    checks++;
    if (early !== 1'b0 || done_after !== 1'b0) begin
      errors++; $display("FAIL %s early_or_long_done: got early=%b done_after=%b required 0 0", nm, early, done_after);
    end
    m_hi = e_hi; m_lo = e_lo;
  endtask

  task automatic test_vectors();
    test_one("mult_neg3x7", 3'b000, 32'hFFFFFFFD, 32'h00000007);
    checks++;
    if ({m_hi, m_lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
      errors++; $display("FAIL mult_vector_model: got %h required FFFFFFFFFFFFFFEB", {m_hi, m_lo});
    end
    test_one("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++;
    if ({bus.hi, bus.lo} !== 64'hFFFFFFFE_00000001) begin
      errors++; $display("FAIL multu_vector: got %h required FFFFFFFE00000001", {bus.hi, bus.lo});
    end
`ifdef MDU_DIV_EN
    test_one("div_neg7by2", 3'b010, 32'hFFFFFFF9, 32'h00000002);
    checks++;
    if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++; $display("FAIL div_vector: got %h required FFFFFFFFFFFFFFFD", {bus.hi, bus.lo});
    end
    test_one("div_overflow", 3'b010, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if ({bus.hi, bus.lo} !== 64'h00000000_80000000) begin
      errors++; $display("FAIL div_overflow_vector: got %h required 0000000080000000", {bus.hi, bus.lo});
    end
    test_one("divu_by_zero", 3'b011, 32'd100, 32'd0);
`else
    test_one("div_absent", 3'b010, 32'd10, 32'd3);
    test_one("divu_absent", 3'b011, 32'd100, 32'd0);
`endif
  endtask

  task automatic test_mt();
    int dones, busys;
    dones = 0; busys = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b100; bus.rsvalue = 32'h12345678;
    @(negedge clk);
    bus.op = 3'b101; bus.rsvalue = 32'h9ABCDEF0;
    if (bus.done) dones++;
    if (bus.busy) busys++;
    @(negedge clk);
    bus.start = 1'b0;
    if (bus.done) dones++;
    if (bus.busy) busys++;
    checks++;
    if ({bus.hi, bus.lo} !== 64'h12345678_9ABCDEF0) begin
      errors++; $display("FAIL mt_values: got %h required 123456789ABCDEF0", {bus.hi, bus.lo});
    end
    @(negedge clk);
    if (bus.done) dones++;
    if (bus.busy) busys++;
    checks++;
    if (dones != 2 || busys != 0) begin
      errors++; $display("FAIL mt_pulses: got done=%0d busy=%0d required 2 0", dones, busys);
    end
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      if ($urandom_range(0, 5) == 0) b = 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) b = 32'h0000FFFF & b;
      if ((o == 3'b010 || o == 3'b011) && $urandom_range(0, 4) == 0) b = 32'h0;
      test_one("random", o, a, b);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r1, r2;
    logic [31:0] a, b, c, d;
    logic got, disturbed;
    int done_at;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    r1 = ref_mul(3'b001, a, b);
    r2 = ref_mul(3'b000, c, d);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b001; bus.rsvalue = a; bus.rtvalue = b;
    @(negedge clk);
    bus.start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got || {bus.hi, bus.lo} !== r1) begin
      errors++; $display("FAIL b2b_first: got done=%b hilo=%h required 1 %h", got, {bus.hi, bus.lo}, r1);
    end
    bus.start = 1'b1; bus.op = 3'b000; bus.rsvalue = c; bus.rtvalue = d;
    @(negedge clk);
    bus.start = 1'b0;
    disturbed = 1'b0; done_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.done) begin done_at = k; break; end
      if ({bus.hi, bus.lo} !== r1) disturbed = 1'b1;
    end
    checks++;
    if (disturbed !== 1'b0 || done_at != 32) begin
      errors++; $display("FAIL b2b_second_timing: got disturbed=%b done_at=%0d required 0 32", disturbed, done_at);
    end
    checks++;
    if ({bus.hi, bus.lo} !== r2) begin
      errors++; $display("FAIL b2b_second_value: got %h required %h", {bus.hi, bus.lo}, r2);
    end
    m_hi = r2[63:32]; m_lo = r2[31:0];
  endtask

  task automatic test_reserved();
    logic bad;
    bad = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b110; bus.rsvalue = 32'hDEAD0001;
    @(negedge clk);
    bus.op = 3'b111;
    if (bus.done || bus.busy) bad = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (bus.done || bus.busy) bad = 1'b1;
    @(negedge clk);
    if (bus.done || bus.busy) bad = 1'b1;
    checks++;
    if (bad !== 1'b0 || {bus.hi, bus.lo} !== {m_hi, m_lo}) begin
      errors++; $display("FAIL reserved_op: got activity=%b hilo=%h required 0 %h", bad, {bus.hi, bus.lo}, {m_hi, m_lo});
    end
  endtask

  task automatic test_abort();
    logic bad, any_done;
    bad = 1'b0; any_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b001; bus.rsvalue = 32'h0000FFFF; bus.rtvalue = 32'h00010001;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 4) begin
        bus.start = 1'b1; bus.op = 3'b101; bus.rsvalue = 32'hDEADBEEF;
      end else begin
        bus.start = 1'b0;
      end
      if (!bus.busy || bus.done || {bus.hi, bus.lo} !== {m_hi, m_lo}) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL abort_ignored_start: got disturbance=%b hilo=%h required 0 %h", bad, {bus.hi, bus.lo}, {m_hi, m_lo});
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero} !== 67'h0) begin
      errors++; $display("FAIL abort_reset_outputs: got %h required 0", {bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero});
    end
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) any_done = 1'b1;
    end
    checks++;
    if (any_done !== 1'b0 || {bus.hi, bus.lo} !== 64'h0) begin
      errors++; $display("FAIL abort_no_done: got activity=%b hilo=%h required 0 0", any_done, {bus.hi, bus.lo});
    end
  endtask

  task automatic test_first_accept();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b1; bus.op = 3'b100; bus.rsvalue = 32'hA5A5A5A5;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.hi !== 32'hA5A5A5A5 || bus.done !== 1'b1) begin
      errors++; $display("FAIL first_accept: got hi=%h done=%b required a5a5a5a5 1", bus.hi, bus.done);
    end
    m_hi = 32'hA5A5A5A5; m_lo = 32'h0;
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'b000; bus.rsvalue = 32'h0; bus.rtvalue = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_vectors();
    test_mt();
    test_random();
    test_back_to_back();
    test_reserved();
    test_abort();
    test_first_accept();
    test_one("after_reset_mult", 3'b000, 32'h7FFFFFFF, 32'h80000000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_hilo.md
MDU_HILO -- requirements
Module: mdu_hilo

Interface
REQ-001 Parameters: none; widths fixed at 32-bit operands, 64-bit product.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled each rising edge.
REQ-005 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-006 rsvalue  input  32  operand A / dividend / MTHI-MTLO source (register-file rs read port).
REQ-007 rtvalue  input  32  operand B / divisor (register-file rt read port, ALUSrc=0 path).
REQ-008 busy  output  1  iterative operation in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 div_zero  output  1  valid with done; divisor was zero.
REQ-011 hi  output  32  HI register.
REQ-012 lo  output  32  LO register.

Function
REQ-013 Accept edge = rising edge with start=1, busy=0, op not reserved; rsvalue, rtvalue, op latched there.
REQ-014 start while busy=1 ignored, no state change; reserved op ignored, no done.
REQ-015 MULT/MULTU: shift-add, one iteration per edge, 32 iterations on edges E1..E32 after accept edge E0.
REQ-016 At E32: {hi,lo} <= 64-bit product, busy <= 0, done <= 1; busy=1 from E0 to E32.
REQ-017 MULT signed: operate on magnitudes, negate 64-bit result iff operand signs differ; MULTU unsigned.
REQ-018 DIV/DIVU: restoring division, same 32-iteration timing as REQ-015/016; lo <= quotient, hi <= remainder.
REQ-019 DIV signed: quotient truncates toward zero; remainder takes sign of dividend.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000, div_zero=0.
REQ-021 Divisor zero (DIV or DIVU): no iteration, busy stays 0; at E1 done=1, div_zero=1, hi/lo unchanged.
REQ-022 MTHI/MTLO: at E0 hi (resp. lo) <= rsvalue, other register unchanged; done=1 during E0..E1, busy stays 0.
REQ-023 done and div_zero cleared on the edge following their assertion unless a new completion occurs there.
REQ-024 Back-to-back: start accepted in the cycle done=1 (busy=0); new result does not disturb previous hi/lo until its own completion edge.
REQ-025 hi/lo hold value at all times other than completion/MT edges; partial results never visible.
REQ-026 State machine: IDLE -> RUN on MULT/DIV accept with nonzero divisor or MULT; RUN -> IDLE at iteration 32; IDLE -> IDLE for MT ops and divide-by-zero.

Reset
REQ-027 rst=1 asynchronously forces hi=0, lo=0, busy=0, done=0, div_zero=0, state IDLE, iteration counter 0.
REQ-028 rst mid-operation aborts; no done produced for the aborted operation.
REQ-029 First accept possible on first rising edge after rst deasserts.

Configuration
REQ-030 Macro MDU_DIV_EN defined: DIV/DIVU per REQ-018..021.
REQ-031 MDU_DIV_EN undefined: divider datapath absent; DIV/DIVU accepted, at E1 done=1, div_zero=0, hi/lo unchanged, busy stays 0.

Verification
REQ-032 MULT rs=0xFFFFFFFD(-3), rt=0x00000007 -> at E32 hi=0xFFFFFFFF, lo=0xFFFFFFEB, done one cycle, busy 1 for E0..E32.
REQ-033 MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 DIV rs=0xFFFFFFF9(-7), rt=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/0 -> E1 done=1, div_zero=1, hi/lo unchanged.
REQ-035 MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive edges -> hi=0x12345678, lo=0x9ABCDEF0, two done pulses, busy never 1.
REQ-036 MULTU started, second start at E5 ignored, rst pulse at E10 -> all outputs 0 immediately, no done afterwards.
REQ-037 Rebuild without MDU_DIV_EN, DIV 10/3 -> E1 done=1, div_zero=0, hi/lo unchanged.
